// File: rtl/bch_pkg.sv
// rtl/bch_pkg.sv - GF(2^M) helpers, defaults and state encoding for the BCH syndrome chain (BCH_SYND_EVEN_EN)
package bch_pkg;

  localparam int GF_M_DEFAULT = 4;
  localparam logic [4:0] PRIM_POLY_DEFAULT = 5'b10011;
  // Widest field the helpers handle; elements carry one spare bit for the reduction step.
  localparam int GF_MAX_M = 16;

`ifdef BCH_SYND_EVEN_EN
  localparam int BCH_NS_FACTOR = 2;
`else
  localparam int BCH_NS_FACTOR = 1;
`endif

  typedef enum logic [0:0] {ACCUM = 1'b0, DONE = 1'b1} bch_state_e;

  typedef logic [GF_MAX_M:0] gf_elem_t;

  function automatic int gf_degree(input gf_elem_t poly);
    int d;
    d = 0;
    for (int b = 0; b <= GF_MAX_M; b++) begin
      if (((poly >> b) & gf_elem_t'(1)) != '0) d = b;
    end
    return d;
  endfunction

  function automatic gf_elem_t gf_mul_alpha(input gf_elem_t value, input gf_elem_t poly);
    gf_elem_t r;
    r = value << 1;
    if (((r >> gf_degree(poly)) & gf_elem_t'(1)) != '0) r = r ^ poly;
    return r;
  endfunction

  // Multiply by alpha^power; power is a constant at every call site, so this folds to XOR logic.
  function automatic gf_elem_t gf_mul_alpha_pow(input gf_elem_t value, input int power,
                                                input gf_elem_t poly);
    gf_elem_t r;
    r = value;
    for (int b = 0; b < power; b++) r = gf_mul_alpha(r, poly);
    return r;
  endfunction

  function automatic gf_elem_t gf_square(input gf_elem_t value, input gf_elem_t poly);
    gf_elem_t r;
    gf_elem_t a;
    r = '0;
    a = value;
    for (int b = 0; b < GF_MAX_M; b++) begin
      if (((value >> b) & gf_elem_t'(1)) != '0) r = r ^ a;
      a = gf_mul_alpha(a, poly);
    end
    return r;
  endfunction

  // Odd part of a syndrome index: S(j) = S(odd_part(j)) squared two_exp(j) times.
  function automatic int odd_part(input int j);
    int v;
    v = j;
    for (int b = 0; b < 32; b++) begin
      if (v > 0 && (v % 2) == 0) v = v / 2;
    end
    return v;
  endfunction

  function automatic int two_exp(input int j);
    int v;
    int e;
    v = j;
    e = 0;
    for (int b = 0; b < 32; b++) begin
      if (v > 0 && (v % 2) == 0) begin
        v = v / 2;
        e = e + 1;
      end
    end
    return e;
  endfunction

endpackage

// File: rtl/bch_gf_const_mul.sv
// rtl/bch_gf_const_mul.sv - combinational multiply by the constant alpha^J in GF(2^M)
module bch_gf_const_mul
  import bch_pkg::*;
#(
  parameter int M = GF_M_DEFAULT,
  parameter logic [M:0] PRIM_POLY = (M+1)'(PRIM_POLY_DEFAULT),
  parameter int J = 1
) (
  input  logic [M-1:0] a,
  output logic [M-1:0] y
);

  // Constant-exponent product, reduced by the field polynomial
  always_comb y = M'(gf_mul_alpha_pow(gf_elem_t'(a), J, gf_elem_t'(PRIM_POLY)));

endmodule

// File: rtl/bch_syndrome_serial.sv
// rtl/bch_syndrome_serial.sv - bit-serial Horner BCH syndrome calculator; BCH_SYND_EVEN_EN adds squared even syndromes
module bch_syndrome_serial
  import bch_pkg::*;
#(
  parameter int M = GF_M_DEFAULT,
  parameter int N = 2**M - 1,
  parameter int T = 3,
  parameter logic [M:0] PRIM_POLY = (M+1)'(PRIM_POLY_DEFAULT),
  localparam int NS = BCH_NS_FACTOR * T
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_bit,
  output logic            in_ready,
  output logic            synd_valid,
  input  logic            synd_ready,
  output logic [NS*M-1:0] synd,
  output logic            err_detect
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [0:0] ST_ACCUM = 1'(ACCUM);
  localparam logic [0:0] ST_DONE  = 1'(DONE);

  logic [0:0]      state;
  logic [CW-1:0]   cnt;
  logic [M-1:0]    acc      [T];
  logic [M-1:0]    mul_out  [T];
  logic [M-1:0]    acc_next [T];
  logic [NS*M-1:0] synd_c;
  logic [NS*M-1:0] synd_q;
  logic            err_q;

  // One constant multiplier per odd syndrome S(2i+1)
  for (genvar gi = 0; gi < T; gi++) begin : g_mul
    bch_gf_const_mul #(
      .M(M),
      .PRIM_POLY(PRIM_POLY),
      .J(2*gi + 1)
    ) u_mul (
      .a(acc[gi]),
      .y(mul_out[gi])
    );
  end

  // Horner step: A_i * alpha^(2i+1) + incoming coefficient
  always_comb begin
    for (int i = 0; i < T; i++) acc_next[i] = mul_out[i] ^ M'(in_bit);
  end

  // Pack the syndrome vector from the post-update accumulators so it can latch on the last accept
  for (genvar gk = 0; gk < NS; gk++) begin : g_pack
`ifdef BCH_SYND_EVEN_EN
    localparam int SRC = (odd_part(gk + 1) - 1) / 2;
    localparam int SQ  = two_exp(gk + 1);
    logic [M-1:0] sv;
    // S(k+1) = S(odd)^(2^SQ); odd indices take SQ=0 and pass straight through
    always_comb begin
      sv = acc_next[SRC];
      for (int s = 0; s < SQ; s++) sv = M'(gf_square(gf_elem_t'(sv), gf_elem_t'(PRIM_POLY)));
    end
    assign synd_c[gk*M +: M] = sv;
`else
    assign synd_c[gk*M +: M] = acc_next[gk];
`endif
  end

  // Accumulate bits in ACCUM, hold the latched result in DONE until the consumer takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_ACCUM;
      cnt    <= '0;
      synd_q <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < T; i++) acc[i] <= '0;
    end else if (state == ST_ACCUM) begin
      if (in_valid) begin
        for (int i = 0; i < T; i++) acc[i] <= acc_next[i];
        if (cnt == LAST) begin
          synd_q <= synd_c;
          err_q  <= |synd_c;
          cnt    <= '0;
          state  <= ST_DONE;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end else if (synd_ready) begin
      state <= ST_ACCUM;
      for (int i = 0; i < T; i++) acc[i] <= '0;
    end
  end

  assign in_ready   = !rst && (state == ST_ACCUM);
  assign synd_valid = (state == ST_DONE);
  assign synd       = synd_q;
  assign err_detect = err_q;

endmodule

// File: tb/tb_bch_syndrome_serial.sv
// tb/tb_bch_syndrome_serial.sv - randomized self-checking bench for bch_syndrome_serial (BCH_SYND_EVEN_EN aware)
module tb_bch_syndrome_serial;

`ifdef BCH_SYND_EVEN_EN
  localparam int FAC = 2;
`else
  localparam int FAC = 1;
`endif
  localparam int NS0 = FAC * 3;
  localparam int W0  = NS0 * 4;
  localparam int NS1 = FAC * 2;
  localparam int W1  = NS1 * 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_bit = 1'b0, synd_ready = 1'b1;
  logic in_ready, synd_valid, err_detect;
  logic [W0-1:0] synd;

  logic m5_in_valid = 1'b0, m5_in_bit = 1'b0;
  logic m5_in_ready, m5_synd_valid, m5_err_detect;
  logic [W1-1:0] m5_synd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bch_syndrome_serial dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .synd_valid(synd_valid), .synd_ready(synd_ready), .synd(synd), .err_detect(err_detect)
  );

  bch_syndrome_serial #(.M(5), .N(31), .T(2), .PRIM_POLY(6'b100101)) dut_m5 (
    .clk(clk), .rst(rst), .in_valid(m5_in_valid), .in_bit(m5_in_bit), .in_ready(m5_in_ready),
    .synd_valid(m5_synd_valid), .synd_ready(1'b1), .synd(m5_synd), .err_detect(m5_err_detect)
  );

  // alpha^e by repeated doubling modulo the field polynomial
  function automatic int alpha_pow(input int m, input int poly, input int e);
    int p = 1;
    for (int i = 0; i < e; i++) begin
      p = p << 1;
      if (((p >> m) & 1) != 0) p = p ^ poly;
    end
    return p;
  endfunction

  // Direct evaluation S_j = sum over set bits r_b of alpha^(j*b)
  function automatic logic [63:0] model_synd(input int m, input int poly, input int n,
                                             input int ns, input logic [30:0] w);
    logic [63:0] r = '0;
    int q = (1 << m) - 1;
    for (int k = 0; k < ns; k++) begin
      int j = (FAC == 2) ? k + 1 : 2*k + 1;
      int s = 0;
      for (int b = 0; b < n; b++) if (w[b]) s = s ^ alpha_pow(m, poly, (j*b) % q);
      r = r | (64'(s) << (k*m));
    end
    return r;
  endfunction

  task automatic drive_word(input logic [14:0] w, input int nbits, input int gap_max);
    for (int idx = 0; idx < nbits; idx++) begin
      int g;
      int guard;
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (g) begin
        in_valid = 1'b0; in_bit = 1'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1; in_bit = w[14-idx];
      guard = 0;
      while (!in_ready && guard < 100) begin
        @(posedge clk); #1; guard++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL in_ready_wait bit=%0d got=%b want=1", idx, in_ready);
      end
      checks++;
      if (synd_valid !== 1'b0) begin
        errors++; $display("FAIL early_synd_valid bit=%0d got=%b want=0", idx, synd_valid);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [14:0] w, input bit handshake);
    logic [W0-1:0] exp;
    exp = W0'(model_synd(4, 'b10011, 15, NS0, 31'(w)));
    checks++;
    if (synd_valid !== 1'b1) begin
      errors++; $display("FAIL %s synd_valid got=%b want=1", name, synd_valid);
    end
    checks++;
    if (synd !== exp) begin
      errors++; $display("FAIL %s synd got=%h want=%h", name, synd, exp);
    end
    checks++;
    if (err_detect !== (exp != '0)) begin
      errors++; $display("FAIL %s err_detect got=%b want=%b", name, err_detect, exp != '0);
    end
    if (handshake) begin
      @(posedge clk); #1;
      checks++;
      if (synd_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s handshake got valid=%b ready=%b want valid=0 ready=1", name, synd_valid, in_ready);
      end
    end
  endtask

  task automatic pulse_rst(input string name);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (synd_valid !== 1'b0 || synd !== '0 || err_detect !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s reset got valid=%b synd=%h err=%b ready=%b want 0,0,0,0", name, synd_valid, synd, err_detect, in_ready);
    end
    rst = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_after_rst got=%b want=1", name, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; synd_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0 || synd_valid !== 1'b0 || synd !== '0 || err_detect !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got ready=%b valid=%b synd=%h err=%b want 0,0,0,0", in_ready, synd_valid, synd, err_detect);
    end
    rst = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release got ready=%b want=1", in_ready);
    end
  endtask

  task automatic test_all_zero();
    drive_word(15'd0, 15, 0);
    checks++;
    if (synd !== '0 || err_detect !== 1'b0) begin
      errors++; $display("FAIL all_zero got synd=%h err=%b want 0,0", synd, err_detect);
    end
    check_result("all_zero", 15'd0, 1'b1);
  endtask

  task automatic test_codeword();
    drive_word(15'b000010100110111, 15, 1);
    checks++;
    if (synd !== '0 || err_detect !== 1'b0) begin
      errors++; $display("FAIL codeword got synd=%h err=%b want 0,0", synd, err_detect);
    end
    check_result("codeword", 15'b000010100110111, 1'b1);
  endtask

  task automatic test_r1();
    logic [W0-1:0] exp;
`ifdef BCH_SYND_EVEN_EN
    exp = 24'b1100_0110_0011_1000_0100_0010;
`else
    exp = 12'b0110_1000_0010;
`endif
    drive_word(15'b10, 15, 0);
    checks++;
    if (synd !== exp || err_detect !== 1'b1) begin
      errors++; $display("FAIL r1_const got synd=%h err=%b want %h,1", synd, err_detect, exp);
    end
    check_result("r1", 15'b10, 1'b1);
  endtask

  task automatic test_r0_stall();
    logic [W0-1:0] exp;
    exp = {NS0{4'b0001}};
    synd_ready = 1'b0;
    drive_word(15'b1, 15, 3);
    check_result("r0", 15'b1, 1'b0);
    in_valid = 1'b1; in_bit = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (synd_valid !== 1'b1 || synd !== exp || in_ready !== 1'b0 || err_detect !== 1'b1) begin
        errors++;
        $display("FAIL r0_hold cyc=%0d got valid=%b synd=%h ready=%b err=%b want 1,%h,0,1", c, synd_valid, synd, in_ready, err_detect, exp);
      end
    end
    in_valid = 1'b0; synd_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (synd_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL r0_release got valid=%b ready=%b want 0,1", synd_valid, in_ready);
    end
  endtask

  task automatic test_rst_abort();
    logic [14:0] w;
    drive_word(15'b10, 7, 1);
    pulse_rst("abort_r1");
    drive_word(15'd0, 15, 0);
    check_result("abort_r1_zero", 15'd0, 1'b1);
    drive_word(15'h7FFF, 7, 0);
    pulse_rst("abort_ones");
    w = 15'($urandom);
    drive_word(w, 15, 1);
    check_result("abort_ones_rand", w, 1'b1);
    synd_ready = 1'b0;
    drive_word(15'h5A5A, 15, 0);
    pulse_rst("abort_done");
    synd_ready = 1'b1;
    drive_word(15'd0, 15, 0);
    check_result("abort_done_zero", 15'd0, 1'b1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      logic [14:0] w;
      w = 15'($urandom);
      drive_word(w, 15, 2);
      check_result("random", w, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] w [3];
    for (int r = 0; r < 3; r++) w[r] = 15'($urandom);
    for (int r = 0; r < 3; r++) begin
      drive_word(w[r], 15, 0);
      check_result("b2b", w[r], 1'b0);
    end
    @(posedge clk); #1;
  endtask

  task automatic drive_m5(input logic [30:0] w);
    for (int idx = 0; idx < 31; idx++) begin
      int guard = 0;
      m5_in_valid = 1'b1; m5_in_bit = w[30-idx];
      while (!m5_in_ready && guard < 100) begin
        @(posedge clk); #1; guard++;
      end
      checks++;
      if (m5_in_ready !== 1'b1 || m5_synd_valid !== 1'b0) begin
        errors++; $display("FAIL m5_accept bit=%0d got ready=%b valid=%b want 1,0", idx, m5_in_ready, m5_synd_valid);
      end
      @(posedge clk); #1;
    end
    m5_in_valid = 1'b0;
  endtask

  task automatic test_m5();
    logic [W1-1:0] exp_c;
    logic [30:0] w;
`ifdef BCH_SYND_EVEN_EN
    exp_c = {5'b10000, 5'b01000, 5'b00100, 5'b00010};
`else
    exp_c = {5'b01000, 5'b00010};
`endif
    drive_m5(31'b10);
    checks++;
    if (m5_synd_valid !== 1'b1 || m5_synd !== exp_c || m5_err_detect !== 1'b1) begin
      errors++; $display("FAIL m5_r1 got valid=%b synd=%h err=%b want 1,%h,1", m5_synd_valid, m5_synd, m5_err_detect, exp_c);
    end
    checks++;
    if (m5_synd !== W1'(model_synd(5, 'b100101, 31, NS1, 31'b10))) begin
      errors++; $display("FAIL m5_r1_model got=%h want=%h", m5_synd, W1'(model_synd(5, 'b100101, 31, NS1, 31'b10)));
    end
    @(posedge clk); #1;
    w = 31'($urandom);
    drive_m5(w);
    checks++;
    if (m5_synd !== W1'(model_synd(5, 'b100101, 31, NS1, w)) || m5_synd_valid !== 1'b1) begin
      errors++; $display("FAIL m5_random got=%h want=%h", m5_synd, W1'(model_synd(5, 'b100101, 31, NS1, w)));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_all_zero();
    test_codeword();
    test_r1();
    test_r0_stall();
    test_rst_abort();
    test_random();
    test_back_to_back();
    test_m5();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
